// File: rtl/fma_operand_fetcher_pkg.sv
// Shared types and defaults for the FMA operand fetcher and its downstream memory buffer.
// Holds the operand-select and state enums, the BRAM tag layout and issue-order helpers.
package fma_operand_fetcher_pkg;

   localparam int DEFAULT_FMA_COUNT    = 2;
   localparam int DEFAULT_WIDTH        = 16;
   localparam int DEFAULT_ADDR_WIDTH   = 11;
   localparam int DEFAULT_BRAM_LATENCY = 2;
   localparam int FMA_IDX_W            = 8;

   typedef enum logic [1:0] {
      OP_A = 2'd0,
      OP_B = 2'd1,
      OP_C = 2'd2
   } op_sel_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_PRESENT = 3'd3,
      ST_HOLDOFF = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic                 valid;
      logic [FMA_IDX_W-1:0] fma_idx;
      op_sel_t              op_sel;
   } fetch_tag_t;

   // c is the final operand of an FMA only when c is being loaded
   function automatic logic is_last_op(op_sel_t op, logic load_c);
      return load_c ? (op == OP_C) : (op == OP_B);
   endfunction

   function automatic op_sel_t next_op_sel(op_sel_t op, logic load_c);
      if (is_last_op(op, load_c)) begin
         return OP_A;
      end
      return (op == OP_A) ? OP_B : OP_C;
   endfunction

endpackage

// File: rtl/fma_operand_fetcher_if.sv
// Command, BRAM read and operand-presentation bundle of the FMA operand fetcher.
// The master modport is the fetcher side; slave is the side driving commands and BRAM data.
interface fma_operand_fetcher_if
   import fma_operand_fetcher_pkg::*;
#(
   parameter int FMA_COUNT  = DEFAULT_FMA_COUNT,
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

   logic                                cmd_valid_in;
   logic                                cmd_ready_out;
   logic [ADDR_WIDTH-1:0]               cmd_a_base_in;
   logic [ADDR_WIDTH-1:0]               cmd_b_base_in;
   logic [ADDR_WIDTH-1:0]               cmd_c_base_in;
   logic                                cmd_load_c_in;
   logic [ADDR_WIDTH-1:0]               bram_addr_out;
   logic [WIDTH-1:0]                    bram_data_in;
   logic [FMA_COUNT-1:0][3*WIDTH-1:0]   abc_out;
   logic [FMA_COUNT-1:0][2:0]           abc_valid_out;
   logic                                busy_out;

   modport master (
      input  cmd_valid_in, cmd_a_base_in, cmd_b_base_in, cmd_c_base_in, cmd_load_c_in,
      input  bram_data_in,
      output cmd_ready_out, bram_addr_out, abc_out, abc_valid_out, busy_out
   );

   modport slave (
      output cmd_valid_in, cmd_a_base_in, cmd_b_base_in, cmd_c_base_in, cmd_load_c_in,
      output bram_data_in,
      input  cmd_ready_out, bram_addr_out, abc_out, abc_valid_out, busy_out
   );

endinterface

// File: rtl/fma_operand_fetcher_tag_pipe.sv
// Delay line that carries each BRAM read's destination tag alongside the read latency.
// pending_out flags tags still in flight that will not exit on the coming edge.
module fma_operand_fetcher_tag_pipe
   import fma_operand_fetcher_pkg::*;
#(
   parameter int LATENCY = DEFAULT_BRAM_LATENCY
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  fetch_tag_t tag_in,
   output fetch_tag_t tag_out,
   output logic       pending_out
);

   fetch_tag_t [LATENCY-1:0] stage_reg;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stage_reg <= '0;
      end else begin
         stage_reg[0] <= tag_in;
         for (int i = 1; i < LATENCY; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tag_out = stage_reg[LATENCY-1];

   always_comb begin
      pending_out = 1'b0;
      for (int i = 0; i < LATENCY - 1; i++) begin
         pending_out = pending_out | stage_reg[i].valid;
      end
   end

endmodule

// File: rtl/fma_operand_fetcher.sv
// Fetches a/b(/c) operands for every FMA from the operand BRAM, stages them, and presents
// all of them to the memory buffer in a single cycle followed by a one-cycle holdoff.
module fma_operand_fetcher
   import fma_operand_fetcher_pkg::*;
#(
   parameter int FMA_COUNT    = DEFAULT_FMA_COUNT,
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int BRAM_LATENCY = DEFAULT_BRAM_LATENCY
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   fma_operand_fetcher_if.master bus
);

   fetch_state_t          state_reg, state_next;
   logic [ADDR_WIDTH-1:0] a_base_reg, b_base_reg, c_base_reg;
   logic                  load_c_reg;
   logic [FMA_IDX_W-1:0]  fma_idx_reg;
   op_sel_t               op_sel_reg;
   logic [ADDR_WIDTH-1:0] op_base;
   logic [ADDR_WIDTH-1:0] bram_addr_reg, bram_addr_next;
   fetch_tag_t            tag_reg, tag_next, tag_exit;
   logic                  pipe_pending;
   logic                  cmd_ready_reg, cmd_ready_next;
   logic                  busy_reg, busy_next;
   logic                  present_next;
   logic [2:0]            abc_valid_reg, abc_valid_next;
   logic                  accept, last_issue, drain_done;

   assign accept     = (state_reg == ST_IDLE) && cmd_ready_reg && bus.cmd_valid_in;
   assign last_issue = (state_reg == ST_ISSUE)
                       && (fma_idx_reg == FMA_IDX_W'(FMA_COUNT - 1))
                       && is_last_op(op_sel_reg, load_c_reg);
   // Drain is over once the only remaining tag is the one exiting on this edge
   assign drain_done = !tag_reg.valid && !pipe_pending;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:    if (accept)     state_next = ST_ISSUE;
         ST_ISSUE:   if (last_issue) state_next = ST_DRAIN;
         ST_DRAIN:   if (drain_done) state_next = ST_PRESENT;
         ST_PRESENT: state_next = ST_HOLDOFF;
         ST_HOLDOFF: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_next = (state_next == ST_IDLE);
      busy_next      = (state_next != ST_IDLE);
      present_next   = (state_next == ST_PRESENT);
      abc_valid_next = present_next ? {2'b11, load_c_reg} : 3'b000;
   end

   always_comb begin
      tag_next       = '0;
      op_base        = a_base_reg;
      bram_addr_next = bram_addr_reg;
      if (state_reg == ST_ISSUE) begin
         case (op_sel_reg)
            OP_A:    op_base = a_base_reg;
            OP_B:    op_base = b_base_reg;
            default: op_base = c_base_reg;
         endcase
         bram_addr_next   = op_base + ADDR_WIDTH'(fma_idx_reg);
         tag_next.valid   = 1'b1;
         tag_next.fma_idx = fma_idx_reg;
         tag_next.op_sel  = op_sel_reg;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         a_base_reg    <= '0;
         b_base_reg    <= '0;
         c_base_reg    <= '0;
         load_c_reg    <= 1'b0;
         fma_idx_reg   <= '0;
         op_sel_reg    <= OP_A;
         bram_addr_reg <= '0;
         tag_reg       <= '0;
         cmd_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         abc_valid_reg <= 3'b000;
      end else begin
         if (accept) begin
            a_base_reg  <= bus.cmd_a_base_in;
            b_base_reg  <= bus.cmd_b_base_in;
            c_base_reg  <= bus.cmd_c_base_in;
            load_c_reg  <= bus.cmd_load_c_in;
            fma_idx_reg <= '0;
            op_sel_reg  <= OP_A;
         end else if (state_reg == ST_ISSUE) begin
            op_sel_reg <= next_op_sel(op_sel_reg, load_c_reg);
            if (is_last_op(op_sel_reg, load_c_reg)) begin
               fma_idx_reg <= fma_idx_reg + FMA_IDX_W'(1);
            end
         end
         bram_addr_reg <= bram_addr_next;
         tag_reg       <= tag_next;
         cmd_ready_reg <= cmd_ready_next;
         busy_reg      <= busy_next;
         abc_valid_reg <= abc_valid_next;
      end
   end

   fma_operand_fetcher_tag_pipe #(
      .LATENCY(BRAM_LATENCY)
   ) u_tag_pipe (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .tag_in      (tag_reg),
      .tag_out     (tag_exit),
      .pending_out (pipe_pending)
   );

   genvar gi;
   generate
      for (gi = 0; gi < FMA_COUNT; gi++) begin : g_fma
         logic [3*WIDTH-1:0] staging_reg, staging_next;
         logic [3*WIDTH-1:0] abc_reg;

         always_comb begin
            staging_next = staging_reg;
            if (tag_exit.valid && (tag_exit.fma_idx == FMA_IDX_W'(gi))) begin
               case (tag_exit.op_sel)
                  OP_A:    staging_next[3*WIDTH-1:2*WIDTH] = bus.bram_data_in;
                  OP_B:    staging_next[2*WIDTH-1:WIDTH]   = bus.bram_data_in;
                  default: staging_next[WIDTH-1:0]         = bus.bram_data_in;
               endcase
            end
         end

         // Presentation takes staging_next so the final BRAM word lands in the same edge
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               staging_reg <= '0;
               abc_reg     <= '0;
            end else begin
               staging_reg <= accept ? '0 : staging_next;
               if (present_next) begin
                  abc_reg <= staging_next;
               end
            end
         end

         assign bus.abc_out[gi]       = abc_reg;
         assign bus.abc_valid_out[gi] = abc_valid_reg;
      end
   endgenerate

   assign bus.bram_addr_out = bram_addr_reg;
   assign bus.cmd_ready_out = cmd_ready_reg;
   assign bus.busy_out      = busy_reg;

endmodule
